// File: rtl/reset_gen_pkg.sv
// Shared encodings for the board reset sequencer: FSM states, reset-cause codes, output bundle.
// Imported by reset_gen; the state and cause values are fixed because software reads res_cause.
package reset_gen_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2,
        SW_HOLD = 2'd3
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_PIN = 2'b01,
        CAUSE_SW  = 2'b10
    } rst_cause_e;

    typedef struct packed {
        logic       tim_res;
        logic       nres;
        logic       reset_to;
        rst_cause_e cause;
    } rst_out_t;

    localparam rst_out_t OUT_RESET = '{
        tim_res:  1'b1,
        nres:     1'b0,
        reset_to: 1'b0,
        cause:    CAUSE_POR
    };

endpackage

// File: rtl/reset_sync_deb.sv
// Reset-button synchroniser with optional debouncer (RESET_DEBOUNCE_EN); act=1 means button pressed.
// Latency: SYNC_STAGES cycles to the synced level, plus DEB_CYC cycles of stability when debouncing.
// Backpressure: none; act is a free-running level.
module reset_sync_deb #(
`ifdef RESET_DEBOUNCE_EN
    parameter int unsigned DEB_CYC     = 50000,
`endif
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic res,
    input  logic din_n,
    output logic act
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   synced_n;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], din_n};
    assign synced_n = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (res) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef RESET_DEBOUNCE_EN
    localparam int unsigned      DEB_W    = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic             act_q;
    logic             act_d;
    logic [DEB_W-1:0] deb_q;
    logic [DEB_W-1:0] deb_d;

    // Count cycles the synced level disagrees with the accepted one; any return restarts the count.
    always_comb begin
        act_d = act_q;
        deb_d = '0;
        if (synced_n == act_q) begin
            if (deb_q == DEB_LAST) begin
                act_d = ~act_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            act_q <= 1'b0;
            deb_q <= '0;
        end else begin
            act_q <= act_d;
            deb_q <= deb_d;
        end
    end

    assign act = act_q;
`else
    assign act = ~synced_n;
`endif

endmodule

// File: rtl/reset_gen.sv
// Board reset sequencer: button -> tim_res release -> stretch -> nres release; sw_res gives a core-only reset.
// Latency: button edge to outputs SYNC_STAGES+DEB_CYC+1 cycles (SYNC_STAGES+1 without RESET_DEBOUNCE_EN).
// Backpressure: none; every output is a registered level or one-cycle pulse.
module reset_gen
    import reset_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
`ifdef RESET_DEBOUNCE_EN
    parameter int unsigned DEB_CYC     = 50000,
`endif
    parameter int unsigned STRETCH_W   = 24,
    parameter int unsigned STRETCH_CYC = 8000000,
    parameter int unsigned SW_MIN      = 16
) (
    input  logic       clk,
    input  logic       res,
    input  logic       inp_resn,
    input  logic       sw_res,
    output logic       tim_res,
    output logic       nres,
    output logic       reset_to,
    output logic [1:0] res_cause
);

    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(STRETCH_CYC - 1);
    localparam logic [STRETCH_W-1:0] SW_LAST      = STRETCH_W'(SW_MIN - 1);

    logic                 pin_act;
    rst_state_e           state_q;
    rst_state_e           state_d;
    logic [STRETCH_W-1:0] cnt_q;
    logic [STRETCH_W-1:0] cnt_d;
    rst_cause_e           cause_d;
    rst_out_t             out_q;
    rst_out_t             out_d;

    reset_sync_deb #(
`ifdef RESET_DEBOUNCE_EN
        .DEB_CYC     (DEB_CYC),
`endif
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_deb (
        .clk   (clk),
        .res   (res),
        .din_n (inp_resn),
        .act   (pin_act)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = out_q.cause;
        case (state_q)
            HOLD: begin
                if (!pin_act) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
            end
            STRETCH: begin
                if (pin_act) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == STRETCH_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                // The pin takes priority so a simultaneous request still resets the clock tree.
                if (pin_act) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_PIN;
                end else if (sw_res) begin
                    state_d = SW_HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_SW;
                end
            end
            SW_HOLD: begin
                if (pin_act) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_PIN;
                end else if ((cnt_q >= SW_LAST) && !sw_res) begin
                    state_d = RUN;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the FSM;
        // reset_to marks the final stretch cycle, the one just before nres rises.
        out_d.tim_res  = (state_d == HOLD);
        out_d.nres     = (state_d == RUN);
        out_d.reset_to = (state_d == STRETCH) && (cnt_d == STRETCH_LAST);
        out_d.cause    = cause_d;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            out_q   <= OUT_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign tim_res   = out_q.tim_res;
    assign nres      = out_q.nres;
    assign reset_to  = out_q.reset_to;
    assign res_cause = out_q.cause;

endmodule

// File: tb/tb_reset_gen.sv
// Randomized scenario bench for reset_gen: expected output-change events are queued from timing rules,
// and a negedge monitor compares every observed output change against the head of the queue.
module tb_reset_gen;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int STR  = 8;
    localparam int SWM  = 3;
`ifdef RESET_DEBOUNCE_EN
    localparam int LAT    = SYNC + DEB + 1;
    localparam int MINLEN = DEB;
    localparam int CMIN   = DEB - 1;
`else
    localparam int LAT    = SYNC + 1;
    localparam int MINLEN = 1;
    localparam int CMIN   = 0;
`endif

    logic       clk;
    logic       res;
    logic       inp_resn;
    logic       sw_res;
    logic       tim_res;
    logic       nres;
    logic       reset_to;
    logic [1:0] res_cause;

    reset_gen #(
        .SYNC_STAGES (SYNC),
`ifdef RESET_DEBOUNCE_EN
        .DEB_CYC     (DEB),
`endif
        .STRETCH_W   (24),
        .STRETCH_CYC (STR),
        .SW_MIN      (SWM)
    ) dut (
        .clk       (clk),
        .res       (res),
        .inp_resn  (inp_resn),
        .sw_res    (sw_res),
        .tim_res   (tim_res),
        .nres      (nres),
        .reset_to  (reset_to),
        .res_cause (res_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Monitor: every change of {tim_res,nres,reset_to,res_cause} must match the next expected event.
    logic [4:0] prev;
    bit         seen = 0;
    always @(negedge clk) begin
        logic [4:0] cur;
        ev_t        e;
        cur = {tim_res, nres, reset_to, res_cause};
        if (cyc >= 1 && (!seen || cur !== prev)) begin
            seen = 1;
            prev = cur;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b required no change", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    errors++;
                    $display("FAIL output_event got cyc=%0d val=%b required cyc=%0d val=%b",
                             cyc, cur, e.cyc, e.val);
                end
            end
        end
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic ex(input int c, input logic t, input logic n, input logic r, input logic [1:0] k);
        ev_t e;
        e.cyc = c;
        e.val = {t, n, r, k};
        exp_q.push_back(e);
    endtask

    // tim_res falls at t0, reset_to marks the last stretch cycle, nres rises STR cycles after t0.
    task automatic ex_release(input int t0, input logic [1:0] k);
        ex(t0, 1'b0, 1'b0, 1'b0, k);
        ex(t0 + STR - 1, 1'b0, 1'b0, 1'b1, k);
        ex(t0 + STR, 1'b0, 1'b1, 1'b0, k);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained cyc=%0d pending=%0d required 0 (next cyc=%0d)",
                     name, cyc, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    // res sampled high on edges n+1..n+k.
    task automatic por(input int n, input int k);
        ex(n + 1, 1'b1, 1'b0, 1'b0, 2'd0);
        ex_release(n + k + 1, 2'd0);
        goto(n);
        res = 1'b1;
        goto(n + k);
        res = 1'b0;
        goto(n + k + 1 + STR + 3);
        drained("por");
    endtask

    // Button low, sampled on edges n+1..n+len.
    task automatic pin_press(input int n, input int len);
        int last;
        if (len >= MINLEN) begin
            ex(n + LAT, 1'b1, 1'b0, 1'b0, 2'd1);
            ex_release(n + len + LAT, 2'd1);
            last = n + len + LAT + STR;
        end else begin
            last = n + len + LAT;
        end
        goto(n);
        inp_resn = 1'b0;
        goto(n + len);
        inp_resn = 1'b1;
        goto(last + 3);
        drained("pin");
    endtask

    task automatic sw_pulse(input int n, input int w);
        int rel;
        rel = n + imax(SWM, w) + 1;
        ex(n + 1, 1'b0, 1'b0, 1'b0, 2'd2);
        ex(rel, 1'b0, 1'b1, 1'b0, 2'd2);
        goto(n);
        sw_res = 1'b1;
        goto(n + w);
        sw_res = 1'b0;
        goto(rel + 3);
        drained("sw");
    endtask

    // Second press reaches the FSM while the stretch counter holds c.
    task automatic stretch_int(input int n0, input int len0, input int c, input int len1);
        int r;
        int n1;
        r  = n0 + len0;
        n1 = r + c + 1;
        ex(n0 + LAT, 1'b1, 1'b0, 1'b0, 2'd1);
        ex(r + LAT, 1'b0, 1'b0, 1'b0, 2'd1);
        ex(n1 + LAT, 1'b1, 1'b0, 1'b0, 2'd1);
        ex_release(n1 + len1 + LAT, 2'd1);
        goto(n0);
        inp_resn = 1'b0;
        goto(r);
        inp_resn = 1'b1;
        goto(n1);
        inp_resn = 1'b0;
        goto(n1 + len1);
        inp_resn = 1'b1;
        goto(n1 + len1 + LAT + STR + 3);
        drained("stretch");
    endtask

    // sw_res rises on the same FSM edge as pin_act and stays high through HOLD and part of STRETCH.
    task automatic simult(input int n, input int len);
        ex(n + LAT, 1'b1, 1'b0, 1'b0, 2'd1);
        ex_release(n + len + LAT, 2'd1);
        goto(n);
        inp_resn = 1'b0;
        goto(n + LAT - 1);
        sw_res = 1'b1;
        goto(n + len);
        inp_resn = 1'b1;
        goto(n + len + 2);
        sw_res = 1'b0;
        goto(n + len + LAT + STR + 3);
        drained("simult");
    endtask

    task automatic res_mid_sw(input int n, input int w, input int off);
        int m;
        m = n + off;
        ex(n + 1, 1'b0, 1'b0, 1'b0, 2'd2);
        ex(m, 1'b1, 1'b0, 1'b0, 2'd0);
        ex_release(m + 1, 2'd0);
        goto(n);
        sw_res = 1'b1;
        goto(m - 1);
        res = 1'b1;
        goto(m);
        res = 1'b0;
        goto(n + w);
        sw_res = 1'b0;
        goto(m + 1 + STR + 3);
        drained("res_mid_sw");
    endtask

    initial begin
        res      = 1'b0;
        inp_resn = 1'b1;
        sw_res   = 1'b0;

        por(0, 3);
        pin_press(cyc + 2, 10);
        pin_press(cyc + 2, 2);
        sw_pulse(cyc + 2, 1);
        sw_pulse(cyc + 2, 6);
        stretch_int(cyc + 2, MINLEN + 2, (CMIN > 5) ? CMIN : 5, MINLEN + 1);
        simult(cyc + 2, LAT + 2);
        res_mid_sw(cyc + 2, 6, 3);

        for (int i = 0; i < 30; i++) begin
            int kind;
            int w;
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: pin_press(cyc + 2, int'($urandom_range(1, 12)));
                1: sw_pulse(cyc + 2, int'($urandom_range(1, 8)));
                2: stretch_int(cyc + 2, MINLEN + int'($urandom_range(0, 5)),
                               int'($urandom_range(CMIN, STR - 2)), MINLEN + int'($urandom_range(0, 5)));
                3: simult(cyc + 2, LAT + int'($urandom_range(0, 4)));
                4: begin
                    w = int'($urandom_range(4, 8));
                    res_mid_sw(cyc + 2, w, int'($urandom_range(2, w)));
                end
                default: por(cyc + 2, int'($urandom_range(1, 4)));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog cyc=%0d required run to complete", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
